// File: rtl/lsu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : lsu_pkg
// Brief    : Shared funct3 encodings and FSM state type for the load/store unit
// Revision : 1.0
// ============================================================================
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        MERGE = 3'd2,
        WRITE = 3'd3,
        RESP  = 3'd4
    } lsu_state_e;

endpackage
`default_nettype wire

// File: rtl/lsu_lane_align.sv
`default_nettype none
// ============================================================================
// Module   : lsu_lane_align
// Brief    : Load lane extract/extend and sub-word store merge (combinational)
// Revision : 1.0
// ============================================================================
module lsu_lane_align
    import lsu_pkg::*;
#(
    parameter int DataWidth = 32
) (
    input  logic [2:0]           funct3,
    input  logic [1:0]           addr_lo,
    input  logic [DataWidth-1:0] word,
    input  logic [DataWidth-1:0] wdata,
    output logic [DataWidth-1:0] load_data,
    output logic [DataWidth-1:0] merge_data
);

    logic [DataWidth-1:0] shifted;
    logic [7:0]           lane_byte;
    logic [15:0]          lane_half;

    always_comb begin
        shifted   = word >> {addr_lo, 3'b000};
        lane_byte = shifted[7:0];
        lane_half = shifted[15:0];
        case (funct3)
            F3_B:    load_data = {{(DataWidth-8){lane_byte[7]}}, lane_byte};
            F3_H:    load_data = {{(DataWidth-16){lane_half[15]}}, lane_half};
            F3_BU:   load_data = {{(DataWidth-8){1'b0}}, lane_byte};
            F3_HU:   load_data = {{(DataWidth-16){1'b0}}, lane_half};
            default: load_data = word;
        endcase
    end

    // Only lanes selected by the store width are replaced; the rest keep the read word
    always_comb begin
        merge_data = word;
        case (funct3)
            F3_B: begin
                case (addr_lo)
                    2'd0:    merge_data[7:0]   = wdata[7:0];
                    2'd1:    merge_data[15:8]  = wdata[7:0];
                    2'd2:    merge_data[23:16] = wdata[7:0];
                    default: merge_data[31:24] = wdata[7:0];
                endcase
            end
            F3_H: begin
                if (addr_lo[1]) merge_data[31:16] = wdata[15:0];
                else            merge_data[15:0]  = wdata[15:0];
            end
            default: merge_data = wdata;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
// Module   : load_store_unit
// Brief    : Sequences core loads/stores onto a word-wide memory port with RMW
// Revision : 1.0
// ============================================================================
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int AddrWidth = 32,
    parameter int DataWidth = 32
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 reqValid,
    output logic                 reqReady,
    input  logic                 reqWrite,
    input  logic [2:0]           reqFunct3,
    input  logic [AddrWidth-1:0] reqAddr,
    input  logic [DataWidth-1:0] reqWData,
    input  logic [AddrWidth-1:0] reqPc,
    output logic                 rspValid,
    input  logic                 rspReady,
    output logic [DataWidth-1:0] rspData,
    output logic                 rspErr,
    output logic [AddrWidth-1:0] memAddr,
    output logic                 memReadEnable,
    input  logic [DataWidth-1:0] memReadData,
    output logic                 memWriteEnable,
    output logic [DataWidth-1:0] memWriteData,
    output logic [AddrWidth-1:0] pcReadData
);

    lsu_state_e           state;
    logic [2:0]           funct3_lat;
    logic [1:0]           addr_lo_lat;
    logic [DataWidth-1:0] wdata_lat;
    logic                 req_err;
    logic [AddrWidth-1:0] word_addr;
    logic [DataWidth-1:0] load_data;
    logic [DataWidth-1:0] merge_data;

    assign word_addr = {reqAddr[AddrWidth-1:2], 2'b00};

    always_comb begin
        req_err = 1'b0;
        if (reqWrite) begin
            case (reqFunct3)
                F3_B:    req_err = 1'b0;
                F3_H:    req_err = reqAddr[0];
                F3_W:    req_err = |reqAddr[1:0];
                default: req_err = 1'b1;
            endcase
        end else begin
            case (reqFunct3)
                F3_B, F3_BU: req_err = 1'b0;
                F3_H, F3_HU: req_err = reqAddr[0];
                F3_W:        req_err = |reqAddr[1:0];
                default:     req_err = 1'b1;
            endcase
        end
    end

    lsu_lane_align #(
        .DataWidth (DataWidth)
    ) u_lane_align (
        .funct3     (funct3_lat),
        .addr_lo    (addr_lo_lat),
        .word       (memReadData),
        .wdata      (wdata_lat),
        .load_data  (load_data),
        .merge_data (merge_data)
    );

    // Every memory-facing output is a register so the write strobe cannot glitch
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state          <= IDLE;
            funct3_lat     <= 3'b000;
            addr_lo_lat    <= 2'b00;
            wdata_lat      <= '0;
            reqReady       <= 1'b1;
            rspValid       <= 1'b0;
            rspData        <= '0;
            rspErr         <= 1'b0;
            memAddr        <= '0;
            memReadEnable  <= 1'b0;
            memWriteEnable <= 1'b0;
            memWriteData   <= '0;
            pcReadData     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (reqValid && reqReady) begin
                        funct3_lat  <= reqFunct3;
                        addr_lo_lat <= reqAddr[1:0];
                        wdata_lat   <= reqWData;
                        pcReadData  <= reqPc;
                        reqReady    <= 1'b0;
                        if (req_err) begin
                            state    <= RESP;
                            rspValid <= 1'b1;
                            rspErr   <= 1'b1;
                            rspData  <= '0;
                        end else if (!reqWrite) begin
                            state         <= LOAD;
                            memReadEnable <= 1'b1;
                            memAddr       <= word_addr;
                        end else if (reqFunct3 == F3_W) begin
                            state          <= WRITE;
                            memWriteEnable <= 1'b1;
                            memWriteData   <= reqWData;
                            memAddr        <= word_addr;
                        end else begin
                            state         <= MERGE;
                            memReadEnable <= 1'b1;
                            memAddr       <= word_addr;
                        end
                    end
                end
                LOAD: begin
                    state         <= RESP;
                    memReadEnable <= 1'b0;
                    memAddr       <= '0;
                    rspValid      <= 1'b1;
                    rspErr        <= 1'b0;
                    rspData       <= load_data;
                end
                MERGE: begin
                    state          <= WRITE;
                    memReadEnable  <= 1'b0;
                    memWriteEnable <= 1'b1;
                    memWriteData   <= merge_data;
                end
                WRITE: begin
                    state          <= RESP;
                    memWriteEnable <= 1'b0;
                    memWriteData   <= '0;
                    memAddr        <= '0;
                    rspValid       <= 1'b1;
                    rspErr         <= 1'b0;
                    rspData        <= '0;
                end
                RESP: begin
                    if (rspReady) begin
                        state    <= IDLE;
                        rspValid <= 1'b0;
                        rspErr   <= 1'b0;
                        rspData  <= '0;
                        reqReady <= 1'b1;
                    end
                end
                default: begin
                    state          <= IDLE;
                    reqReady       <= 1'b1;
                    rspValid       <= 1'b0;
                    rspErr         <= 1'b0;
                    rspData        <= '0;
                    memAddr        <= '0;
                    memReadEnable  <= 1'b0;
                    memWriteEnable <= 1'b0;
                    memWriteData   <= '0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
